// File: rtl/imem_uart_loader_pkg.sv
// Shared types and default framing constants for the UART instruction-memory loader.
package imem_uart_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CSUM,
    ST_RESP
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [7:0] ACK_BYTE_DEF  = 8'h06;
  localparam logic [7:0] NAK_BYTE_DEF  = 8'h15;

  // Bytes arrive least-significant first, so each new byte enters at the top.
  function automatic logic [31:0] pack_le(input logic [31:0] word, input logic [7:0] b);
    return {b, word[31:8]};
  endfunction

endpackage

// File: rtl/imem_uart_loader_timeout.sv
// Inter-byte idle timer: reloads on every accepted byte, flags expiry after TIMEOUT_CYC idle clocks.
module imem_uart_loader_timeout #(
  parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(TIMEOUT_CYC);
    end else if (!run) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count of 1 means this edge is the TIMEOUT_CYC-th idle clock since the last byte.
  assign expire = run && (cnt_q == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// Receives a framed program image over UART, writes it to instruction memory and
// keeps the core in reset until a checksummed image has been fully loaded.
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned MAX_WORDS   = 1024,
  parameter int unsigned TIMEOUT_CYC = 5_000_000,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter logic [7:0]  ACK_BYTE    = ACK_BYTE_DEF,
  parameter logic [7:0]  NAK_BYTE    = NAK_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  state_e              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [31:0]         word_q, word_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
  logic [7:0]          csum_q, csum_d;
  logic                resp_ack_q, resp_ack_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                load_done_q, load_done_d;
  logic                load_err_q, load_err_d;

  logic active;
  logic is_sync;
  logic tmr_load;
  logic tmr_expire;
  logic timeout;
  logic len_bad;
  logic last_word;
  logic resp_go;
  logic resp_ack;
  logic [31:0] packed_word;

  assign active    = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                     (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign is_sync   = rx_valid && (rx_data == SYNC_BYTE);
  assign tmr_load  = rx_valid && (active || ((state_q == ST_IDLE) && is_sync));
  // A byte arriving on the expiry edge wins over the timeout.
  assign timeout   = active && tmr_expire && !rx_valid;
  assign len_bad   = (len_q == 16'd0) || (32'(len_q) > MAX_WORDS);
  assign last_word = (32'(word_idx_q) + 32'd1) == 32'(len_q);
  assign packed_word = pack_le(word_q, rx_data);

  imem_uart_loader_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .run    (active),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_d       = word_q;
    byte_cnt_d   = byte_cnt_q;
    word_idx_d   = word_idx_q;
    csum_d       = csum_q;
    resp_ack_d   = resp_ack_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_hold_d   = cpu_hold_q;
    load_done_d  = load_done_q;
    load_err_d   = load_err_q;
    resp_go      = 1'b0;
    resp_ack     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (is_sync) begin
          state_d     = ST_LEN0;
          cpu_hold_d  = 1'b1;
          load_done_d = 1'b0;
          load_err_d  = 1'b0;
          len_d       = '0;
          word_d      = '0;
          byte_cnt_d  = '0;
          word_idx_d  = '0;
          csum_d      = '0;
        end
      end

      ST_LEN0: begin
        if (rx_valid) begin
          len_d[7:0] = rx_data;
          csum_d     = csum_q ^ rx_data;
          state_d    = ST_LEN1;
        end else if (timeout) begin
          resp_go = 1'b1;
        end
      end

      ST_LEN1: begin
        if (rx_valid) begin
          len_d[15:8] = rx_data;
          csum_d      = csum_q ^ rx_data;
          state_d     = ST_DATA;
        end else if (timeout) begin
          resp_go = 1'b1;
        end
      end

      ST_DATA: begin
        if (len_bad) begin
          resp_go = 1'b1;
        end else if (rx_valid) begin
          word_d     = packed_word;
          csum_d     = csum_q ^ rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_idx_q;
            imem_wdata_d = packed_word;
            word_idx_d   = word_idx_q + ADDR_W'(1);
            if (last_word) begin
              state_d = ST_CSUM;
            end
          end
        end else if (timeout) begin
          resp_go = 1'b1;
        end
      end

      ST_CSUM: begin
        if (rx_valid) begin
          resp_go  = 1'b1;
          resp_ack = (rx_data == csum_q);
        end else if (timeout) begin
          resp_go = 1'b1;
        end
      end

      ST_RESP: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = ST_IDLE;
          if (resp_ack_q) begin
            load_done_d = 1'b1;
            cpu_hold_d  = 1'b0;
          end else begin
            load_err_d = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (resp_go) begin
      state_d    = ST_RESP;
      resp_ack_d = resp_ack;
      tx_valid_d = 1'b1;
      tx_data_d  = resp_ack ? ACK_BYTE : NAK_BYTE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      word_q       <= '0;
      byte_cnt_q   <= '0;
      word_idx_q   <= '0;
      csum_q       <= '0;
      resp_ack_q   <= 1'b0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_hold_q   <= 1'b1;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_q       <= word_d;
      byte_cnt_q   <= byte_cnt_d;
      word_idx_q   <= word_idx_d;
      csum_q       <= csum_d;
      resp_ack_q   <= resp_ack_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader with a short inter-byte timeout.
module tb_imem_uart_loader;

  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              tx_ready = 1'b1;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  int checks   = 0;
  int failures = 0;
  int we_count = 0;
  int tx_count = 0;
  int w0;
  int t0;

  imem_uart_loader #(
    .ADDR_W      (ADDR_W),
    .MAX_WORDS   (1024),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_we) we_count++;
    if (tx_valid && tx_ready) tx_count++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents one byte for exactly one rising edge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    idle(3);
    check("rst_cpu_hold",  32'(cpu_hold), 32'd1);
    check("rst_tx_valid",  32'(tx_valid), 32'd0);
    check("rst_tx_data",   32'(tx_data), 32'd0);
    check("rst_imem_we",   32'(imem_we), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_err",  32'(load_err), 32'd0);
    rst = 1'b1;
    idle(2);

    // Good two-word frame
    w0 = we_count; t0 = tx_count;
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h93); send(8'h00); send(8'h50); send(8'h00);
    check("good_w0_we",   32'(imem_we), 32'd1);
    check("good_w0_addr", 32'(imem_addr), 32'd0);
    check("good_w0_data", imem_wdata, 32'h0050_0093);
    send(8'h13);
    check("good_we_pulse", 32'(imem_we), 32'd0);
    send(8'h00); send(8'h00); send(8'h00);
    check("good_w1_we",   32'(imem_we), 32'd1);
    check("good_w1_addr", 32'(imem_addr), 32'd1);
    check("good_w1_data", imem_wdata, 32'h0000_0013);
    send(8'hD2);
    check("good_tx_valid", 32'(tx_valid), 32'd1);
    check("good_tx_data",  32'(tx_data), 32'h06);
    check("good_hold_pre", 32'(cpu_hold), 32'd1);
    idle(1);
    check("good_tx_drop",   32'(tx_valid), 32'd0);
    check("good_load_done", 32'(load_done), 32'd1);
    check("good_load_err",  32'(load_err), 32'd0);
    check("good_cpu_hold",  32'(cpu_hold), 32'd0);
    check("good_writes",    32'(we_count - w0), 32'd2);
    check("good_tx_count",  32'(tx_count - t0), 32'd1);

    // Same frame, wrong checksum
    w0 = we_count;
    send(8'hA5);
    check("bad_sync_hold", 32'(cpu_hold), 32'd1);
    check("bad_sync_done", 32'(load_done), 32'd0);
    send(8'h02); send(8'h00);
    send(8'h93); send(8'h00); send(8'h50); send(8'h00);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    send(8'hD3);
    check("bad_tx_valid", 32'(tx_valid), 32'd1);
    check("bad_tx_data",  32'(tx_data), 32'h15);
    idle(1);
    check("bad_load_err",  32'(load_err), 32'd1);
    check("bad_load_done", 32'(load_done), 32'd0);
    check("bad_cpu_hold",  32'(cpu_hold), 32'd1);
    check("bad_writes",    32'(we_count - w0), 32'd2);

    // Zero length
    send(8'hA5);
    check("len0_err_clr", 32'(load_err), 32'd0);
    send(8'h00); send(8'h00);
    check("len0_no_tx_yet", 32'(tx_valid), 32'd0);
    idle(1);
    check("len0_tx_valid", 32'(tx_valid), 32'd1);
    check("len0_tx_data",  32'(tx_data), 32'h15);
    idle(1);
    check("len0_load_err", 32'(load_err), 32'd1);

    // Length 1025 exceeds the maximum
    w0 = we_count;
    send(8'hA5); send(8'h01); send(8'h04);
    idle(1);
    check("len1025_tx_valid", 32'(tx_valid), 32'd1);
    check("len1025_tx_data",  32'(tx_data), 32'h15);
    idle(1);
    check("len1025_load_err", 32'(load_err), 32'd1);
    check("len1025_writes",   32'(we_count - w0), 32'd0);

    // Timeout after two data bytes
    w0 = we_count;
    send(8'hA5); send(8'h01); send(8'h00); send(8'h93); send(8'h00);
    idle(63);
    check("to_63_no_tx", 32'(tx_valid), 32'd0);
    idle(1);
    check("to_64_tx_valid", 32'(tx_valid), 32'd1);
    check("to_64_tx_data",  32'(tx_data), 32'h15);
    idle(1);
    check("to_load_err", 32'(load_err), 32'd1);
    check("to_writes",   32'(we_count - w0), 32'd0);

    // Bytes landing exactly on the expiry clock keep the frame alive
    send(8'hA5); send(8'h01); send(8'h00); send(8'h93); send(8'h00);
    idle(63);
    send(8'h50);
    check("alive_b3_no_tx", 32'(tx_valid), 32'd0);
    idle(63);
    send(8'h00);
    check("alive_we",   32'(imem_we), 32'd1);
    check("alive_addr", 32'(imem_addr), 32'd0);
    check("alive_data", imem_wdata, 32'h0050_0093);
    check("alive_no_tx", 32'(tx_valid), 32'd0);
    send(8'hC2);
    check("alive_tx_data", 32'(tx_data), 32'h06);
    idle(1);
    check("alive_load_done", 32'(load_done), 32'd1);

    // Response stalled by tx_ready
    tx_ready = 1'b0;
    send(8'hA5); send(8'h00); send(8'h00);
    idle(1);
    t0 = tx_count;
    for (int i = 0; i < 20; i++) begin
      check("stall_tx_valid", 32'(tx_valid), 32'd1);
      check("stall_tx_data",  32'(tx_data), 32'h15);
      idle(1);
    end
    check("stall_no_accept", 32'(tx_count - t0), 32'd0);
    tx_ready = 1'b1;
    idle(1);
    check("stall_tx_drop",   32'(tx_valid), 32'd0);
    check("stall_one_accept", 32'(tx_count - t0), 32'd1);
    check("stall_load_err",  32'(load_err), 32'd1);

    // Reset mid-frame, then a clean one-word frame
    t0 = tx_count;
    send(8'hA5); send(8'h01); send(8'h00); send(8'h93); send(8'h00);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    check("mid_rst_hold",  32'(cpu_hold), 32'd1);
    check("mid_rst_tx",    32'(tx_valid), 32'd0);
    idle(1);
    check("mid_rst_no_nak", 32'(tx_count - t0), 32'd0);
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    check("post_rst_we",   32'(imem_we), 32'd1);
    check("post_rst_addr", 32'(imem_addr), 32'd0);
    check("post_rst_data", imem_wdata, 32'h0000_0013);
    send(8'h12);
    check("post_rst_tx_data", 32'(tx_data), 32'h06);
    idle(1);
    check("post_rst_done", 32'(load_done), 32'd1);
    check("post_rst_hold", 32'(cpu_hold), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
